mux2_4_reg: RTL and testbench
=============================

Name: mux2_4_reg

Overview:
- 4-bit-wide (parameterizable) 2:1 multiplexer with a registered output, used as a datapath select stage.
- Select input s chooses between operand a and operand b; the result is captured on the rising clock edge.
- The combinational select core is a separate leaf so it can be reused unregistered elsewhere.

Parameters:
- WIDTH, 4, bit width of a, b and out.
- RST_VAL, {WIDTH{1'b0}}, value loaded into out on reset.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  data operand selected when s=0.
- b  input  WIDTH  data operand selected when s=1.
- s  input  1  select: 0 -> a, 1 -> b.
- en  input  1  output register load enable; 1 = capture, 0 = hold.
- out  output  WIDTH  registered mux result.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled only on the rising edge of clk.
- Combinational core: sel_data = s ? b : a, bitwise over all WIDTH bits. No other logic. s=X/Z is not a supported input.
- On each rising clk edge, evaluate in priority order:
  - rst=1: out <= RST_VAL. Applies regardless of en, s, a or b.
  - else en=1: out <= sel_data.
  - else: out holds its previous value.
- Latency: exactly 1 clock from a change on a, b or s (with en=1) to out.
- Reset value of out is RST_VAL (all zeros by default). Before the first reset edge, out is undefined.
- Simultaneous rst=1 and en=1: reset wins.
- Reset deasserted mid-stream: the first capture occurs on the first edge where rst=0 and en=1.
- Operand changes between clock edges have no effect on out. Only values present at the edge are captured.
- No arithmetic, so there is no overflow or wrap-around. Width is preserved exactly, with no sign or zero extension.
- The design is fully synchronous, with no latches and no combinational path from inputs to out.

Decomposition:
- Shared package mux2_4_pkg: localparam DEFAULT_WIDTH=4 and constant SEL_A=1'b0, SEL_B=1'b1.
- Sub-module mux2_4_core: purely combinational, parameter WIDTH, ports a, b, s -> y. It is instantiated once inside mux2_4_reg, and the register stage lives in the top.

Test Plan:
- Reset: rst=1, en=1, a=4'b1010, b=4'b0101, s=1 for 2 clocks -> out=4'b0000 on each edge.
- Select A: rst=0, en=1, a=4'b0011, b=4'b1100, s=0 -> out=4'b0011 one clock later. Set s=1 -> out=4'b1100 on the next edge.
- Exhaustive sweep: with en=1, toggle s every clock and step a[1:0] and b[1:0] through all 16 combinations (32 vectors) -> each edge out equals (s ? b : a) from the previous cycle. Check a=0001, b=0010: s=0 -> 0001, s=1 -> 0010.
- Hold: load out=4'b0110, then en=0 while a=4'b1111, b=4'b0000 and s toggles for 3 clocks -> out stays 4'b0110.
- Reset priority mid-operation: out=4'b1001, then assert rst=1 with en=1, s=0, a=4'b1111 -> out=4'b0000 at that edge. Deassert rst -> out=4'b1111 on the next edge.
- Glitch immunity: change a=4'b0111 to 4'b1000 and back to 4'b0111 between edges with s=0 -> out=4'b0111 only, with no 4'b1000 captured.

Source files
------------

// File: rtl/mux2_4_pkg.sv
// Shared constants for the mux2_4 datapath select stage.
// Holds the default operand width and the select encodings.
package mux2_4_pkg;

   localparam int   DEFAULT_WIDTH = 4;
   localparam logic SEL_A         = 1'b0;
   localparam logic SEL_B         = 1'b1;

endpackage

// File: rtl/mux2_4_core.sv
// Purely combinational 2:1 select leaf, reusable without a register stage.
// Each bit is an independent lane, so the select fans out bitwise.
module mux2_4_core
   import mux2_4_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   output logic [WIDTH-1:0] y
);

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_bit
         assign y[i] = (s == SEL_B) ? b[i] : a[i];
      end
   endgenerate

endmodule

// File: rtl/mux2_4_reg.sv
// Registered 2:1 multiplexer: select core followed by a load-enabled output
// register with synchronous reset that takes priority over the enable.
module mux2_4_reg
   import mux2_4_pkg::*;
#(
   parameter int               WIDTH   = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   input  logic             en,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] sel_data;

   mux2_4_core #(.WIDTH(WIDTH)) u_core (
      .a (a),
      .b (b),
      .s (s),
      .y (sel_data)
   );

   // No path from inputs to out other than through this register.
   always_ff @(posedge clk) begin
      if (rst)
         out <= RST_VAL;
      else if (en)
         out <= sel_data;
   end

endmodule

// File: tb/tb_mux2_4_reg.sv
// Directed self-checking bench for mux2_4_reg: reset, select, sweep, hold,
// reset priority and mid-cycle operand glitches.
module tb_mux2_4_reg;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic       s;
   logic       en;
   logic [3:0] out;

   int n_checks = 0;
   int n_fail   = 0;

   mux2_4_reg #(.WIDTH(4), .RST_VAL(4'b0000)) dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .s   (s),
      .en  (en),
      .out (out)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge; inputs change only here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; a = 4'b1010; b = 4'b0101; s = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_checks++;
         if (out !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset[%0d]: got %b expected %b", k, out, 4'b0000);
         end
      end
   endtask

   task automatic test_select();
      rst = 1'b0; en = 1'b1; a = 4'b0011; b = 4'b1100; s = 1'b0;
      tick();
      n_checks++;
      if (out !== 4'b0011) begin
         n_fail++;
         $display("FAIL select_a: got %b expected %b", out, 4'b0011);
      end
      s = 1'b1;
      tick();
      n_checks++;
      if (out !== 4'b1100) begin
         n_fail++;
         $display("FAIL select_b: got %b expected %b", out, 4'b1100);
      end
   endtask

   task automatic test_sweep();
      logic [4:0] v;
      logic [3:0] exp;
      en = 1'b1;
      for (int i = 0; i < 32; i++) begin
         v = i[4:0];
         a = {2'b00, v[4:3]};
         b = {2'b00, v[2:1]};
         s = v[0];
         exp = v[0] ? {2'b00, v[2:1]} : {2'b00, v[4:3]};
         tick();
         n_checks++;
         if (out !== exp) begin
            n_fail++;
            $display("FAIL sweep[%0d]: a=%b b=%b s=%b got %b expected %b",
                     i, a, b, s, out, exp);
         end
      end
      a = 4'b0001; b = 4'b0010; s = 1'b0;
      tick();
      n_checks++;
      if (out !== 4'b0001) begin
         n_fail++;
         $display("FAIL sweep_01_s0: got %b expected %b", out, 4'b0001);
      end
      s = 1'b1;
      tick();
      n_checks++;
      if (out !== 4'b0010) begin
         n_fail++;
         $display("FAIL sweep_01_s1: got %b expected %b", out, 4'b0010);
      end
      // Full-width operands must pass through unchanged.
      a = 4'b1111; b = 4'b1000; s = 1'b1;
      tick();
      n_checks++;
      if (out !== 4'b1000) begin
         n_fail++;
         $display("FAIL width_b: got %b expected %b", out, 4'b1000);
      end
      s = 1'b0;
      tick();
      n_checks++;
      if (out !== 4'b1111) begin
         n_fail++;
         $display("FAIL width_a: got %b expected %b", out, 4'b1111);
      end
   endtask

   task automatic test_hold();
      en = 1'b1; a = 4'b0110; b = 4'b0000; s = 1'b0;
      tick();
      n_checks++;
      if (out !== 4'b0110) begin
         n_fail++;
         $display("FAIL hold_load: got %b expected %b", out, 4'b0110);
      end
      en = 1'b0; a = 4'b1111; b = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         s = ~s;
         tick();
         n_checks++;
         if (out !== 4'b0110) begin
            n_fail++;
            $display("FAIL hold[%0d]: got %b expected %b", k, out, 4'b0110);
         end
      end
   endtask

   task automatic test_reset_priority();
      en = 1'b1; a = 4'b1001; s = 1'b0;
      tick();
      n_checks++;
      if (out !== 4'b1001) begin
         n_fail++;
         $display("FAIL rstprio_load: got %b expected %b", out, 4'b1001);
      end
      rst = 1'b1; en = 1'b1; s = 1'b0; a = 4'b1111;
      tick();
      n_checks++;
      if (out !== 4'b0000) begin
         n_fail++;
         $display("FAIL rstprio_rst: got %b expected %b", out, 4'b0000);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (out !== 4'b1111) begin
         n_fail++;
         $display("FAIL rstprio_release: got %b expected %b", out, 4'b1111);
      end
      // Reset released with en low: reset value held until first enabled edge.
      rst = 1'b1;
      tick();
      rst = 1'b0; en = 1'b0; a = 4'b0101;
      tick();
      n_checks++;
      if (out !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_release_en0: got %b expected %b", out, 4'b0000);
      end
      en = 1'b1;
      tick();
      n_checks++;
      if (out !== 4'b0101) begin
         n_fail++;
         $display("FAIL rst_release_en1: got %b expected %b", out, 4'b0101);
      end
   endtask

   task automatic test_glitch();
      en = 1'b1; s = 1'b0; a = 4'b0111; b = 4'b0000;
      tick();
      n_checks++;
      if (out !== 4'b0111) begin
         n_fail++;
         $display("FAIL glitch_pre: got %b expected %b", out, 4'b0111);
      end
      #2 a = 4'b1000;
      #1;
      n_checks++;
      if (out !== 4'b0111) begin
         n_fail++;
         $display("FAIL glitch_mid: got %b expected %b", out, 4'b0111);
      end
      #1 a = 4'b0111;
      tick();
      n_checks++;
      if (out !== 4'b0111) begin
         n_fail++;
         $display("FAIL glitch_post: got %b expected %b", out, 4'b0111);
      end
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; a = '0; b = '0; s = 1'b0;
      #2;
      test_reset();
      test_select();
      test_sweep();
      test_hold();
      test_reset_priority();
      test_glitch();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
